// File: rtl/zrle_decoder.sv
// Zero-run-length decoder: unpacks an MSB-first ZRLE word stream into one decoded bit per handshake.
// Latency: head '1' of an accepted word is presented the next cycle; a zero run appears after one bubble cycle.
// Backpressure: rdy_i stalls bit emission with outputs held stable; rdy_o drops while the 2-word buffer cannot take a word.
module zrle_decoder #(
  parameter int DATA_W           = 8,
  parameter int LOG_MAX_ZRLE_LEN = 4,
  parameter int BLK_LEN          = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              vld_i,
  output logic              rdy_o,
  output logic              is_one_o,
  output logic              last_o,
  output logic              vld_o,
  input  logic              rdy_i,
  output logic              idle_o
);

  localparam int BUF_W  = 2 * DATA_W;
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam int CNT_W  = $clog2(BLK_LEN + 1);
  localparam int SYM_W  = LOG_MAX_ZRLE_LEN + 1;
  localparam int RUN_W  = LOG_MAX_ZRLE_LEN + 1;
  localparam int OFS_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {DECODE, ZEROS, DRAIN} state_t;

  state_t                      state_q;
  logic [BUF_W-1:0]            buf_q, buf_d;
  logic [FILL_W-1:0]           fill_q, fill_d, fill_rem, consumed;
  logic [CNT_W-1:0]            out_cnt_q, left;
  logic [RUN_W-1:0]            run_q, run_len, run_ld;
  logic [LOG_MAX_ZRLE_LEN-1:0] l_field;
  logic                        head, have_sym, accept, is_last;

  // Buffer is left-aligned, so the next symbol always starts at the MSB.
  assign head     = buf_q[BUF_W-1];
  assign l_field  = buf_q[BUF_W-2 -: LOG_MAX_ZRLE_LEN];
  assign have_sym = fill_q >= FILL_W'(SYM_W);
  assign is_last  = out_cnt_q == CNT_W'(BLK_LEN - 1);

  // Outputs decode registered state only, so they never depend on rdy_i.
  assign vld_o    = (state_q == ZEROS) || ((state_q == DECODE) && (fill_q != '0) && head);
  assign is_one_o = (state_q == DECODE) && (fill_q != '0) && head;
  assign last_o   = vld_o && is_last;
  assign rdy_o    = (state_q != DRAIN) && (fill_q <= FILL_W'(DATA_W));
  assign accept   = vld_i && rdy_o;
  assign idle_o   = (state_q == DECODE) && (fill_q == '0) && (out_cnt_q == '0);

  // Zero run clipped to what is left of the block; the excess is dropped.
  assign run_len  = RUN_W'(l_field) + RUN_W'(1);
  assign left     = CNT_W'(BLK_LEN) - out_cnt_q;
  assign run_ld   = (32'(run_len) > 32'(left)) ? RUN_W'(left) : run_len;

  // Bits consumed this cycle, then the new word appended right after what remains.
  always_comb begin
    consumed = '0;
    case (state_q)
      DECODE: begin
        if (fill_q != '0) begin
          if (head) begin
            if (rdy_i) consumed = FILL_W'(1);
          end else if (have_sym) begin
            consumed = FILL_W'(SYM_W);
          end
        end
      end
      DRAIN:   consumed = FILL_W'(fill_q[OFS_W-1:0]);
      default: consumed = '0;
    endcase
    fill_rem = fill_q - consumed;
    buf_d    = buf_q << consumed;
    fill_d   = fill_rem;
    if (accept) begin
      // Bits below fill are kept zero, so OR-ing the word in is safe.
      buf_d  = buf_d | ({data_i, {DATA_W{1'b0}}} >> fill_rem);
      fill_d = fill_rem + FILL_W'(DATA_W);
    end
  end

  // Bit buffer and fill level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
    end
  end

  // Symbol FSM: emit ones, load and play out zero runs, drop padding at block end.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= DECODE;
      out_cnt_q <= '0;
      run_q     <= '0;
    end else begin
      case (state_q)
        DECODE: begin
          if (fill_q != '0) begin
            if (head) begin
              if (rdy_i) begin
                if (is_last) begin
                  out_cnt_q <= '0;
                  state_q   <= DRAIN;
                end else begin
                  out_cnt_q <= out_cnt_q + CNT_W'(1);
                end
              end
            end else if (have_sym) begin
              run_q   <= run_ld;
              state_q <= ZEROS;
            end
          end
        end
        ZEROS: begin
          if (rdy_i) begin
            run_q <= run_q - RUN_W'(1);
            if (is_last) begin
              out_cnt_q <= '0;
              state_q   <= DRAIN;
            end else begin
              out_cnt_q <= out_cnt_q + CNT_W'(1);
              if (run_q == RUN_W'(1)) state_q <= DECODE;
            end
          end
        end
        DRAIN:   state_q <= DECODE;
        default: state_q <= DECODE;
      endcase
    end
  end

endmodule

// File: tb/tb_zrle_decoder.sv
// Bench for zrle_decoder: two instances (BLK_LEN 16 and 8) driven from a vector table.
// Expected bits are queued when a vector starts and popped on each output handshake.
// Hand sequences cover reset values, first-bit latency and reset in the middle of a zero run.
module tb_zrle_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] data     [2];
  logic       vld_in   [2];
  logic       rdy_out  [2];
  logic       one_out  [2];
  logic       last_out [2];
  logic       vld_out  [2];
  logic       rdy_in   [2];
  logic       idle_out [2];

  zrle_decoder #(.DATA_W(8), .LOG_MAX_ZRLE_LEN(4), .BLK_LEN(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .data_i(data[0]), .vld_i(vld_in[0]), .rdy_o(rdy_out[0]),
    .is_one_o(one_out[0]), .last_o(last_out[0]), .vld_o(vld_out[0]), .rdy_i(rdy_in[0]),
    .idle_o(idle_out[0]));

  zrle_decoder #(.DATA_W(8), .LOG_MAX_ZRLE_LEN(4), .BLK_LEN(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .data_i(data[1]), .vld_i(vld_in[1]), .rdy_o(rdy_out[1]),
    .is_one_o(one_out[1]), .last_o(last_out[1]), .vld_o(vld_out[1]), .rdy_i(rdy_in[1]),
    .idle_o(idle_out[1]));

  typedef struct {
    int          sel;
    int          nw;
    logic [31:0] words;     // first word in [31:24]
    int          nbits;
    logic [63:0] bits;      // bit i = i-th decoded bit
    logic [63:0] lasts;     // bit i = last_o expected on i-th bit
    bit          toggle;
    bit          chk_full;
  } vec_t;

  typedef struct packed {
    logic b;
    logic l;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   tests = 0;
  int   fails = 0;
  int   sel   = 0;
  int   got   = 0;
  logic hold_p = 1'b0;
  logic hold_one, hold_last;

  function automatic void checkb(string name, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void checkn(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Output monitor: scoreboard compare on handshakes, stability check while stalled.
  always @(negedge clk) begin
    if (rst) begin
      hold_p <= 1'b0;
    end else begin
      if (hold_p) begin
        checkb("hold_vld", vld_out[sel], 1'b1);
        checkb("hold_one", one_out[sel], hold_one);
        checkb("hold_last", last_out[sel], hold_last);
      end
      hold_p    <= vld_out[sel] && !rdy_in[sel];
      hold_one  <= one_out[sel];
      hold_last <= last_out[sel];
      if (vld_out[sel] && rdy_in[sel]) begin
        got <= got + 1;
        if (sb.size() == 0) begin
          checkb("extra_bit", 1'b1, 1'b0);
        end else begin
          checkb("bit", one_out[sel], sb[0].b);
          checkb("last", last_out[sel], sb[0].l);
          void'(sb.pop_front());
        end
      end
    end
  end

  // Present one word and hold it until accepted.
  task automatic send_word(input int s, input logic [7:0] w);
    int n = 0;
    data[s]   = w;
    vld_in[s] = 1'b1;
    @(negedge clk);
    while (!rdy_out[s] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) checkb("accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    vld_in[s] = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int start;
    sel   = v.sel;
    start = got;
    for (int i = 0; i < v.nbits; i++) sb.push_back({v.bits[i], v.lasts[i]});
    rdy_in[v.sel] = v.toggle ? 1'b0 : 1'b1;
    fork
      begin
        for (int k = 0; k < v.nw; k++) send_word(v.sel, v.words[31-8*k -: 8]);
        if (v.chk_full) begin
          @(negedge clk);
          checkb("rdy_full", rdy_out[v.sel], 1'b0);
        end
      end
      begin
        int c = 0;
        while ((got - start) < v.nbits && c < 400) begin
          @(posedge clk);
          #1;
          if (v.toggle) rdy_in[v.sel] = ~rdy_in[v.sel];
          c++;
        end
        if ((got - start) < v.nbits) checkn("bits_timeout", got - start, v.nbits);
      end
    join
    rdy_in[v.sel] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkn("bit_count", got - start, v.nbits);
    checkn("sb_empty", sb.size(), 0);
    checkb("idle_after", idle_out[v.sel], 1'b1);
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, want below 500000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    //            sel nw words         nbits bits      lasts     tog  full
    vecs[0] = '{0, 2, 32'h8E90_0000, 16, 64'h0021, 64'h8000, 1'b0, 1'b0}; // mixed block
    vecs[1] = '{0, 1, 32'h7800_0000, 16, 64'h0000, 64'h8000, 1'b0, 1'b0}; // max run
    vecs[2] = '{0, 2, 32'hFFFF_0000, 16, 64'hFFFF, 64'h8000, 1'b1, 1'b1}; // backpressure
    vecs[3] = '{1, 3, 32'hFE00_FF00, 16, 64'hFF7F, 64'h8080, 1'b0, 1'b0}; // straddle + next block
    vecs[4] = '{1, 2, 32'hF780_0000,  8, 64'h000F, 64'h0080, 1'b0, 1'b0}; // truncation
    vecs[5] = '{1, 1, 32'hA800_0000,  8, 64'h0001, 64'h0080, 1'b0, 1'b0}; // clipped run in one word
    vecs[6] = '{1, 2, 32'h1D00_0000,  8, 64'h0010, 64'h0080, 1'b0, 1'b0}; // clipped straddled run

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      data[i] = '0; vld_in[i] = 1'b0; rdy_in[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    checkb("rst_vld", vld_out[0], 1'b0);
    checkb("rst_last", last_out[0], 1'b0);
    checkb("rst_one", one_out[0], 1'b0);
    checkb("rst_rdy", rdy_out[0], 1'b1);
    checkb("rst_idle", idle_out[0], 1'b1);
    checkb("rst_idle8", idle_out[1], 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Head '1': bit valid the cycle after acceptance.
    send_word(0, 8'hFF);
    @(negedge clk);
    checkb("lat1_vld", vld_out[0], 1'b1);
    checkb("lat1_one", one_out[0], 1'b1);
    checkb("lat1_idle", idle_out[0], 1'b0);
    #1 rst = 1'b1;
    #1;
    checkb("rst1_vld", vld_out[0], 1'b0);
    checkb("rst1_idle", idle_out[0], 1'b1);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Head '0'+L=8: one bubble, then zeros; reset in ZEROS with run of 9.
    send_word(0, 8'h40);
    @(negedge clk);
    checkb("lat0_bubble", vld_out[0], 1'b0);
    @(negedge clk);
    checkb("lat0_vld", vld_out[0], 1'b1);
    checkb("lat0_one", one_out[0], 1'b0);
    #1 rst = 1'b1;
    #1;
    checkb("rstz_vld", vld_out[0], 1'b0);
    checkb("rstz_rdy", rdy_out[0], 1'b1);
    checkb("rstz_idle", idle_out[0], 1'b1);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
